// File: rtl/ff_pipe_chain.sv
// ---------------------------------------------------------------------------
// ff_pipe_chain
//   A register pipeline with a configurable number of stages and valid/ready
//   flow control. It stalls when the sink stalls and collapses bubbles.
//   DEPTH = 0 makes it a plain wire.
//
//   Optional feature, selected by the macro FF_PIPE_OCCUPANCY_EN:
//     adds a registered OCCUPANCY port that holds the number of valid stages.
//     When the macro is undefined, the port and the counter are not built.
// ---------------------------------------------------------------------------
module ff_pipe_chain #(
   parameter int               WIDTH   = 18,
   parameter int               DEPTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             SCLR,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_DATA
`ifdef FF_PIPE_OCCUPANCY_EN
   ,
   output logic [((DEPTH == 0) ? 1 : $clog2(DEPTH + 1)) - 1:0] OCCUPANCY
`endif
);

   generate
      if (DEPTH == 0) begin : g_bypass
         // Pure wire. The clock, reset and clear have no effect here.
         logic unused_s;
         assign unused_s  = ^{CLK, RST, SCLR};
         assign OUT_VALID = IN_VALID;
         assign OUT_DATA  = IN_DATA;
         assign IN_READY  = OUT_READY;
`ifdef FF_PIPE_OCCUPANCY_EN
         assign OCCUPANCY = 1'b0;
`endif
      end else begin : g_chain
         logic [DEPTH-1:0] vld_s;
         logic [WIDTH-1:0] dat_s [DEPTH];
         logic [DEPTH-1:0] ready_s;

         for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            logic             vld_r;
            logic [WIDTH-1:0] dat_r;
            logic             up_vld_s;
            logic [WIDTH-1:0] up_dat_s;

            if (g == 0) begin : g_head
               assign up_vld_s = IN_VALID;
               assign up_dat_s = IN_DATA;
            end else begin : g_body
               assign up_vld_s = vld_s[g-1];
               assign up_dat_s = dat_s[g-1];
            end

            // A stage can load if any stage from here to the output is empty,
            // or if the sink is taking the last word. This is the unrolled form
            // of ready[i] = !vld[i] | ready[i+1]. It has no combinational
            // self-dependency.
            assign ready_s[g] = ~(&vld_s[DEPTH-1:g]) | OUT_READY;

            // Stage register: clear on reset, take the upstream word when ready.
            // The data field only changes when a valid word arrives.
            always_ff @(posedge CLK or posedge RST) begin
               if (RST) begin
                  vld_r <= 1'b0;
                  dat_r <= RST_VAL;
               end else if (SCLR) begin
                  vld_r <= 1'b0;
                  dat_r <= RST_VAL;
               end else if (ready_s[g]) begin
                  vld_r <= up_vld_s;
                  if (up_vld_s) begin
                     dat_r <= up_dat_s;
                  end else begin
                     dat_r <= dat_r;
                  end
               end else begin
                  vld_r <= vld_r;
                  dat_r <= dat_r;
               end
            end

            assign vld_s[g] = vld_r;
            assign dat_s[g] = dat_r;
         end

         assign IN_READY  = ready_s[0];
         assign OUT_VALID = vld_s[DEPTH-1];
         assign OUT_DATA  = dat_s[DEPTH-1];

`ifdef FF_PIPE_OCCUPANCY_EN
         localparam int OCC_W = $clog2(DEPTH + 1);
         logic [OCC_W-1:0] occ_r;
         logic             in_fire_s;
         logic             out_fire_s;

         assign in_fire_s  = IN_VALID & ready_s[0];
         assign out_fire_s = vld_s[DEPTH-1] & OUT_READY;

         // Word count. Bubbles moving inside the chain never change it.
         // Only the handshakes at the two ends change it.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               occ_r <= {OCC_W{1'b0}};
            end else if (SCLR) begin
               occ_r <= {OCC_W{1'b0}};
            end else begin
               case ({in_fire_s, out_fire_s})
                  2'b10:   occ_r <= occ_r + OCC_W'(1);
                  2'b01:   occ_r <= occ_r - OCC_W'(1);
                  default: occ_r <= occ_r;
               endcase
            end
         end

         assign OCCUPANCY = occ_r;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_ff_pipe_chain.sv
// ---------------------------------------------------------------------------
// tb_ff_pipe_chain
//   Directed bench for ff_pipe_chain.
//   Instance dut: DEPTH = 3, with a non-zero RST_VAL.
//   Instance byp: DEPTH = 0, the bypass case.
//   Inputs are driven at the falling edge. Outputs are sampled 1 time unit
//   later.
// ---------------------------------------------------------------------------
module tb_ff_pipe_chain;

   localparam int          W  = 18;
   localparam logic [17:0] RV = 18'h2A5A5;

   logic         clk;
   logic         rst;
   logic         sclr;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
`ifdef FF_PIPE_OCCUPANCY_EN
   logic [1:0]   occupancy;
   logic [0:0]   b_occupancy;
`endif

   logic         b_in_valid;
   logic         b_in_ready;
   logic [W-1:0] b_in_data;
   logic         b_out_valid;
   logic         b_out_ready;
   logic [W-1:0] b_out_data;

   int checks = 0;
   int errors = 0;

   ff_pipe_chain #(.WIDTH(W), .DEPTH(3), .RST_VAL(RV)) dut (
      .CLK(clk), .RST(rst), .SCLR(sclr),
      .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data)
`ifdef FF_PIPE_OCCUPANCY_EN
      , .OCCUPANCY(occupancy)
`endif
   );

   ff_pipe_chain #(.WIDTH(W), .DEPTH(0), .RST_VAL(RV)) byp (
      .CLK(clk), .RST(rst), .SCLR(sclr),
      .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_DATA(b_in_data),
      .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_DATA(b_out_data)
`ifdef FF_PIPE_OCCUPANCY_EN
      , .OCCUPANCY(b_occupancy)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then let them settle.
   task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
   endtask

   task automatic check_occ(input string tag, input int exp);
`ifdef FF_PIPE_OCCUPANCY_EN
      check_val(tag, 32'(occupancy), 32'(exp));
`else
      if (exp < 0) $display("occupancy tag %s", tag);
`endif
   endtask

   initial begin
      rst = 1'b1; sclr = 1'b0;
      in_valid = 1'b0; in_data = 18'h0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = 18'h0; b_out_ready = 1'b0;

      // Reset state.
      @(negedge clk); #1;
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_data",  32'(out_data),  32'(RV));
      check_val("rst_in_ready",  32'(in_ready),  32'd1);
      check_occ("rst_occ", 0);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: stream 1..16 back to back, sink always ready.
      // The word presented in cycle n is seen at the output in cycle n+3.
      for (int n = 0; n < 20; n++) begin
         drive(n < 16, 18'(n + 1), 1'b1);
         check_val("t1_in_ready", 32'(in_ready), 32'd1);
         check_val("t1_out_valid", 32'(out_valid), 32'((n >= 3) && (n <= 18)));
         if ((n >= 3) && (n <= 18))
            check_val("t1_out_data", 32'(out_data), 32'(n - 2));
      end

      // Test 2: fill the chain with A, B, C while the sink is stalled.
      drive(1'b1, 18'hA, 1'b0);
      check_val("t2_rdy_a", 32'(in_ready), 32'd1);
      drive(1'b1, 18'hB, 1'b0);
      check_val("t2_rdy_b", 32'(in_ready), 32'd1);
      drive(1'b1, 18'hC, 1'b0);
      check_val("t2_rdy_c", 32'(in_ready), 32'd1);
      // Offer D while full. It must not be taken.
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 18'hD, 1'b0);
         check_val("t2_full_rdy", 32'(in_ready),  32'd0);
         check_val("t2_full_vld", 32'(out_valid), 32'd1);
         check_val("t2_full_dat", 32'(out_data),  32'hA);
         check_occ("t2_full_occ", 3);
      end
      drive(1'b0, 18'h0, 1'b1);
      check_val("t2_d0", 32'(out_data), 32'hA);
      check_val("t2_rdy_open", 32'(in_ready), 32'd1);
      drive(1'b0, 18'h0, 1'b1);
      check_val("t2_d1", 32'(out_data), 32'hB);
      drive(1'b0, 18'h0, 1'b1);
      check_val("t2_d2", 32'(out_data), 32'hC);
      check_val("t2_v2", 32'(out_valid), 32'd1);
      drive(1'b0, 18'h0, 1'b0);
      check_val("t2_empty", 32'(out_valid), 32'd0);
      check_occ("t2_empty_occ", 0);

      // Test 3: valid pattern 1,0,1 with the sink stalled. The bubble collapses.
      drive(1'b1, 18'h11, 1'b0);
      drive(1'b0, 18'h0,  1'b0);
      drive(1'b1, 18'h22, 1'b0);
      check_val("t3_rdy_2nd", 32'(in_ready), 32'd1);
      drive(1'b1, 18'h33, 1'b0);
      check_val("t3_rdy_3rd", 32'(in_ready),  32'd1);
      check_val("t3_vld",     32'(out_valid), 32'd1);
      check_val("t3_dat",     32'(out_data),  32'h11);
      drive(1'b0, 18'h0, 1'b0);
      check_val("t3_full_rdy", 32'(in_ready), 32'd0);
      check_val("t3_full_dat", 32'(out_data), 32'h11);
      check_occ("t3_occ", 3);

      // Test 4: chain is full. Push and pop in the same cycle.
      drive(1'b1, 18'h44, 1'b1);
      check_val("t4_rdy_thru", 32'(in_ready), 32'd1);
      check_val("t4_dat0",     32'(out_data), 32'h11);
      drive(1'b0, 18'h0, 1'b0);
      check_val("t4_rdy_full", 32'(in_ready), 32'd0);
      check_val("t4_dat1",     32'(out_data), 32'h22);
      check_occ("t4_occ", 3);
      drive(1'b0, 18'h0, 1'b1);
      check_val("t4_pop22", 32'(out_data), 32'h22);
      drive(1'b0, 18'h0, 1'b1);
      check_val("t4_pop33", 32'(out_data), 32'h33);
      drive(1'b0, 18'h0, 1'b1);
      check_val("t4_pop44", 32'(out_data), 32'h44);
      drive(1'b0, 18'h0, 1'b1);
      check_val("t4_empty", 32'(out_valid), 32'd0);

      // Test 5a: assert the async reset between edges, mid-stream.
      drive(1'b1, 18'h55, 1'b1);
      drive(1'b1, 18'h66, 1'b1);
      drive(1'b1, 18'h77, 1'b1);
      drive(1'b1, 18'h88, 1'b1);
      check_val("t5_pre_vld", 32'(out_valid), 32'd1);
      check_val("t5_pre_dat", 32'(out_data),  32'h55);
      in_valid = 1'b0;
      out_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_val("t5_arst_vld", 32'(out_valid), 32'd0);
      check_val("t5_arst_dat", 32'(out_data),  32'(RV));
      check_val("t5_arst_rdy", 32'(in_ready),  32'd1);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 18'h0, 1'b1);
      check_val("t5_post_vld", 32'(out_valid), 32'd0);
      check_occ("t5_post_occ", 0);

      // Test 5b: the synchronous clear wins over a push in the same cycle.
      drive(1'b1, 18'h55, 1'b0);
      drive(1'b1, 18'h66, 1'b0);
      drive(1'b1, 18'h77, 1'b0);
      @(negedge clk);
      sclr = 1'b1; in_valid = 1'b1; in_data = 18'h99; out_ready = 1'b0;
      #1;
      check_val("t5_sclr_pre", 32'(out_valid), 32'd1);
      check_val("t5_sclr_pre_dat", 32'(out_data), 32'h55);
      @(negedge clk);
      sclr = 1'b0; in_valid = 1'b0;
      #1;
      check_val("t5_sclr_vld", 32'(out_valid), 32'd0);
      check_val("t5_sclr_dat", 32'(out_data),  32'(RV));
      check_val("t5_sclr_rdy", 32'(in_ready),  32'd1);
      check_occ("t5_sclr_occ", 0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 18'h0, 1'b1);
         check_val("t5_sclr_nodata", 32'(out_valid), 32'd0);
      end

      // Test 6: with DEPTH = 0 the outputs follow the inputs combinationally.
      b_in_valid = 1'b1; b_in_data = 18'h3FFFF; b_out_ready = 1'b0; #1;
      check_val("t6_vld1", 32'(b_out_valid), 32'd1);
      check_val("t6_dat1", 32'(b_out_data),  32'h3FFFF);
      check_val("t6_rdy1", 32'(b_in_ready),  32'd0);
      b_in_valid = 1'b0; b_in_data = 18'h12345; b_out_ready = 1'b1; #1;
      check_val("t6_vld2", 32'(b_out_valid), 32'd0);
      check_val("t6_dat2", 32'(b_out_data),  32'h12345);
      check_val("t6_rdy2", 32'(b_in_ready),  32'd1);
      rst = 1'b1; b_in_valid = 1'b1; #1;
      check_val("t6_rst_vld", 32'(b_out_valid), 32'd1);
      check_val("t6_rst_dat", 32'(b_out_data),  32'h12345);
`ifdef FF_PIPE_OCCUPANCY_EN
      check_val("t6_occ", 32'(b_occupancy), 32'd0);
`endif
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
